// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver, bundled for port grouping.
// The master modport is the receiver itself; the slave modport is the line driver and consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  rx,
    input  ready,
    output data,
    output valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output rx,
    output ready,
    input  data,
    input  valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling with an integer divider,
// valid/ready byte handoff with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_rx_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state_r;
  logic [1:0]    sync_r;
  logic          rx_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic [7:0]    data_r;
  logic          valid_r;
  logic          frame_err_r;
  logic          overrun_r;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], bus.rx};
    end
  end

  assign rx_s = sync_r[1];

  // Receive FSM, shift register and registered handshake/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      // Consumption; a delivery on the same edge overrides this below.
      if (valid_r && bus.ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end

      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (!rx_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end

        START: begin
          if (cnt_r == HALF_M1) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            // A start bit that is gone by mid-bit is a glitch: drop silently.
            if (rx_s) begin
              state_r <= IDLE;
            end else begin
              state_r <= DATA;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end

        DATA: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= '0;
            shift_r <= {rx_s, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end

        STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r <= '0;
            if (rx_s) begin
              state_r <= IDLE;
              if (!valid_r || bus.ready) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= BRK;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end

        BRK: begin
          cnt_r <= '0;
          if (rx_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= BRK;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.data      = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: stimulus pushes expected events with their due cycle,
// a negedge monitor pops and compares whenever the receiver presents an output.
module tb_uart_rx;

  localparam int CPB = 10;
  localparam int H   = CPB / 2;
  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;
  localparam int K_NONE = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  logic v_prev = 1'b0;
  logic r_prev = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors = vectors + 1;
    if (got !== want) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %02h, want %02h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Drives one 8N1 frame starting now; kind says what the receiver should present.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int kind);
    exp_t e;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.data = b;
      e.cyc  = cyc + 3 + H + 9 * CPB;
      q.push_back(e);
    end
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CPB);
    end
    bus.rx = stop_bit;
    tick(CPB);
  endtask

  task automatic check_event(input int kind, input logic [7:0] d);
    exp_t e;
    vectors = vectors + 1;
    if (q.size() == 0) begin
      miscompares = miscompares + 1;
      $display("FAIL unexpected_event: got kind %0d data %02h at cycle %0d, want none", kind, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == K_DATA && e.data !== d)) begin
        miscompares = miscompares + 1;
        $display("FAIL event: got kind %0d data %02h cycle %0d, want kind %0d data %02h cycle %0d",
                 kind, d, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: classify what the receiver presented after each posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err && bus.overrun) begin
        vectors = vectors + 1;
        miscompares = miscompares + 1;
        $display("FAIL pulse_excl: got frame_err=1 overrun=1, want at most one at cycle %0d", cyc);
      end
      if (bus.frame_err) check_event(K_FERR, 8'h00);
      if (bus.overrun) check_event(K_OVR, 8'h00);
      if (bus.valid && (!v_prev || r_prev)) check_event(K_DATA, bus.data);
    end
    v_prev = bus.valid;
    r_prev = bus.ready;
  end

  initial begin
    bus.rx    = 1'b1;
    bus.ready = 1'b0;
    rst_n     = 1'b0;
    tick(3);
    chk("reset_data", bus.data, 8'h00);
    chk("reset_valid", {7'd0, bus.valid}, 8'h00);
    chk("reset_ferr", {7'd0, bus.frame_err}, 8'h00);
    chk("reset_ovr", {7'd0, bus.overrun}, 8'h00);
    rst_n = 1'b1;
    tick(10);

    // Nominal byte with the consumer always ready: valid lasts one cycle.
    bus.ready = 1'b1;
    send_frame(8'hA5, 1'b1, K_DATA);
    chk("nominal_valid_drop", {7'd0, bus.valid}, 8'h00);
    chk("nominal_data_hold", bus.data, 8'hA5);
    tick(5);

    // Short low glitch, then a real byte whose timing proves the FSM returned to IDLE.
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(20);
    chk("glitch_no_valid", {7'd0, bus.valid}, 8'h00);
    send_frame(8'h3C, 1'b1, K_DATA);
    tick(5);

    // Framing error, then a held-low line that must yield nothing.
    send_frame(8'h00, 1'b0, K_FERR);
    tick(50);
    chk("break_no_valid", {7'd0, bus.valid}, 8'h00);
    bus.rx = 1'b1;
    tick(20);
    send_frame(8'hFF, 1'b1, K_DATA);
    tick(5);

    // Overrun: consumer stalled across two back-to-back bytes.
    bus.ready = 1'b0;
    send_frame(8'h11, 1'b1, K_DATA);
    send_frame(8'h22, 1'b1, K_OVR);
    tick(2);
    chk("ovr_held_data", bus.data, 8'h11);
    chk("ovr_held_valid", {7'd0, bus.valid}, 8'h01);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    chk("ovr_consumed", {7'd0, bus.valid}, 8'h00);
    tick(5);

    // Simultaneous accept and delivery: ready high only on the completing edge.
    send_frame(8'h11, 1'b1, K_DATA);
    fork
      send_frame(8'h77, 1'b1, K_DATA);
      begin
        tick(3 + H + 9 * CPB - 1);
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
      end
    join
    chk("simul_data", bus.data, 8'h77);
    chk("simul_valid", {7'd0, bus.valid}, 8'h01);

    // Reset in the middle of DATA while a byte is still held.
    bus.rx = 1'b0;
    tick(30);
    rst_n = 1'b0;
    #1;
    chk("midreset_data", bus.data, 8'h00);
    chk("midreset_valid", {7'd0, bus.valid}, 8'h00);
    chk("midreset_ferr", {7'd0, bus.frame_err}, 8'h00);
    chk("midreset_ovr", {7'd0, bus.overrun}, 8'h00);
    bus.rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(200);
    chk("post_reset_no_valid", {7'd0, bus.valid}, 8'h00);

    vectors = vectors + 1;
    if (q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL pending_events: got %0d outstanding, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the team's UART transmitter: recovers 8-bit bytes from an asynchronous line and hands them to downstream logic over a valid/ready handshake. Samples the line at mid-bit using an integer clocks-per-bit divider and checks the stop bit. Flags framing errors and overruns. Sits between the board-level RX pin and the byte consumer.

## Interface
- CLKS_PER_BIT, 10, clock cycles per serial bit; integer ≥ 4; H = CLKS_PER_BIT/2 (integer division).
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line: idle high, start bit low, 8 data bits LSB first, one stop bit high.
- data  output  8  received byte; valid only while `valid` = 1.
- valid  output  1  byte available; held until consumed.
- ready  input  1  consumer accepts `data` on any posedge where valid & ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the previous one was unconsumed.

## Operation
- The one clock is `clk`. Reset is asynchronous and active-low on `rst_n`.
- rst_n low, asynchronously:
  - two-flop synchronizer → 1; FSM → IDLE; counters → 0; shift register → 0.
  - outputs: data = 0x00, valid = 0, frame_err = 0, overrun = 0.
- A reset mid-frame discards the partial byte and any held byte.
- `rx` passes through the two-flop synchronizer; the FSM sees only the synchronized `rx_s`.
- FSM states:
  - IDLE: rx_s = 0 → START; clear the cycle counter.
  - START: at counter = H−1, sample rx_s. If 0 → DATA with counter and bit index cleared. If 1 → IDLE; treat as a glitch, no flags.
  - DATA: at counter = CLKS_PER_BIT−1, sample rx_s into bit[index] (LSB first) and clear the counter. After bit 7 → STOP.
  - STOP: at counter = CLKS_PER_BIT−1, sample rx_s.
    - If 1: deliver the byte and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: stay until rx_s = 1, then IDLE. A held-low line never produces bytes.
- Delivery rules:
  - valid = 0: load data, set valid.
  - valid = 1 and ready = 1 on the same edge: load the new data, valid stays 1, no overrun.
  - valid = 1 and ready = 0: drop the new byte, keep the old data/valid, pulse overrun.
- Consumption: valid & ready at a posedge with no delivery → valid = 0. data holds its last value.
- ready while valid = 0 has no effect.
- Counter width: $clog2(CLKS_PER_BIT). The counter never exceeds CLKS_PER_BIT−1.
- frame_err and overrun are never asserted in the same cycle.

## Timing
- Synchronizer latency: 2 clk cycles from an rx change to rx_s.
- Let cycle d be the first posedge at which the FSM, in IDLE, sees rx_s = 0.
- Start validation samples at d+H.
- Data bit i samples at d+H+(i+1)·CLKS_PER_BIT, for i = 0..7.
- Stop bit samples at d+H+9·CLKS_PER_BIT. That same edge registers valid/data, or frame_err, or overrun.
- Pulses (frame_err, overrun) are exactly one cycle wide.
- FSM is back in IDLE the cycle after a good stop sample. It can detect the next start bit immediately, supporting back-to-back frames with no idle gap.
- Throughput: one byte per 10·CLKS_PER_BIT cycles.

## Test plan
- Reset: assert rst_n low mid-frame (during DATA) → data = 0x00, valid/frame_err/overrun = 0 immediately. Release with rx high for 200 cycles → no valid.
- Nominal, CLKS_PER_BIT = 10, ready = 1: send 0xA5 → data = 0xA5 and valid rises at d+95. valid is high exactly one cycle; frame_err = 0.
- Glitch: drive rx low for 3 cycles, then high → no valid, FSM back in IDLE. Then send 0x3C → data = 0x3C.
- Framing: send 0x00 with stop bit low and hold rx low 50 cycles → frame_err pulses once at d+95, valid stays 0, no further bytes. Raise rx, then send 0xFF → data = 0xFF, valid = 1.
- Overrun: ready = 0, send 0x11 then 0x22 back-to-back → data = 0x11 with valid held, overrun pulses once at the second stop sample. Raise ready one cycle → valid falls next edge.
- Simultaneous: hold ready low, then raise ready for exactly the edge on which byte 0x77 completes while 0x11 is held → data = 0x77, valid stays 1, overrun = 0.
